// File: rtl/mod_n_updown_counter.sv
// mod_n_updown_counter: modulo-N up/down counter with parallel load.
//
// Counts over 0..MODULUS-1, either wrapping (SATURATE=0) or holding
// (SATURATE=1) at the limits. Per-edge priority: rst, load, en, hold.
//
// Ports:
//   clk       in   clock, rising edge
//   rst       in   synchronous active-high reset
//   en        in   count enable
//   load      in   parallel load strobe (overrides en and mode)
//   mode      in   direction, 1 = up, 0 = down
//   data      in   [WIDTH-1:0] load value
//   count     out  [WIDTH-1:0] registered count
//   wrap      out  registered one-cycle pulse on a wrap transition
//   sat       out  registered one-cycle pulse on a blocked count (SATURATE=1)
//   load_err  out  registered one-cycle pulse on an out-of-range load
//   at_limit  out  combinational: count sits at the limit for the current mode
module mod_n_updown_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 15,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             mode,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             sat,
  output logic             load_err,
  output logic             at_limit
);

  // 64-bit bound so MODULUS = 2**WIDTH is representable for any sane WIDTH.
  localparam longint unsigned RangeMax = 64'd1 << WIDTH;

  if (WIDTH < 1 || WIDTH > 32 || MODULUS < 2 || longint'(MODULUS) > RangeMax ||
      SATURATE > 1) begin : gen_bad_params
    $error("mod_n_updown_counter: illegal WIDTH/MODULUS/SATURATE");
  end

  // MODULUS-1 always fits in WIDTH bits, even when MODULUS = 2**WIDTH.
  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             sat_q, sat_d;
  logic             load_err_q, load_err_d;

  always_comb begin
    count_d    = count_q;
    wrap_d     = 1'b0;
    sat_d      = 1'b0;
    load_err_d = 1'b0;
    if (load) begin
      // data is WIDTH bits, so data >= MODULUS is equivalent to data > MaxVal.
      if (data > MaxVal) begin
        count_d    = MaxVal;
        load_err_d = 1'b1;
      end else begin
        count_d = data;
      end
    end else if (en) begin
      if (mode) begin
        if (count_q == MaxVal) begin
          if (SATURATE == 1) begin
            sat_d = 1'b1;
          end else begin
            count_d = '0;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q + 1'b1;
        end
      end else begin
        if (count_q == '0) begin
          if (SATURATE == 1) begin
            sat_d = 1'b1;
          end else begin
            count_d = MaxVal;
            wrap_d  = 1'b1;
          end
        end else begin
          count_d = count_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q    <= '0;
      wrap_q     <= 1'b0;
      sat_q      <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wrap_q     <= wrap_d;
      sat_q      <= sat_d;
      load_err_q <= load_err_d;
    end
  end

  assign count    = count_q;
  assign wrap     = wrap_q;
  assign sat      = sat_q;
  assign load_err = load_err_q;
  assign at_limit = mode ? (count_q == MaxVal) : (count_q == '0);

endmodule

// File: tb/tb_mod_n_updown_counter.sv
// Directed testbench for mod_n_updown_counter. Three instances:
//   a: defaults (WIDTH=4, MODULUS=15, wrap)
//   b: SATURATE=1, MODULUS=10
//   c: WIDTH=3, MODULUS=8 (full binary range)
module tb_mod_n_updown_counter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Instance a signals
  logic       a_rst, a_en, a_load, a_mode;
  logic [3:0] a_data, a_count;
  logic       a_wrap, a_sat, a_load_err, a_at_limit;
  // Instance b signals
  logic       b_rst, b_en, b_load, b_mode;
  logic [3:0] b_data, b_count;
  logic       b_wrap, b_sat, b_load_err, b_at_limit;
  // Instance c signals
  logic       c_rst, c_en, c_load, c_mode;
  logic [2:0] c_data, c_count;
  logic       c_wrap, c_sat, c_load_err, c_at_limit;

  mod_n_updown_counter u_a (
    .clk(clk), .rst(a_rst), .en(a_en), .load(a_load), .mode(a_mode), .data(a_data),
    .count(a_count), .wrap(a_wrap), .sat(a_sat), .load_err(a_load_err),
    .at_limit(a_at_limit)
  );

  mod_n_updown_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) u_b (
    .clk(clk), .rst(b_rst), .en(b_en), .load(b_load), .mode(b_mode), .data(b_data),
    .count(b_count), .wrap(b_wrap), .sat(b_sat), .load_err(b_load_err),
    .at_limit(b_at_limit)
  );

  mod_n_updown_counter #(.WIDTH(3), .MODULUS(8), .SATURATE(0)) u_c (
    .clk(clk), .rst(c_rst), .en(c_en), .load(c_load), .mode(c_mode), .data(c_data),
    .count(c_count), .wrap(c_wrap), .sat(c_sat), .load_err(c_load_err),
    .at_limit(c_at_limit)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One rising edge, then sample 1 time unit later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    a_rst = 1; a_en = 0; a_load = 0; a_mode = 0; a_data = '0;
    b_rst = 1; b_en = 0; b_load = 0; b_mode = 0; b_data = '0;
    c_rst = 1; c_en = 0; c_load = 0; c_mode = 0; c_data = '0;
    step();
    step();

    // Reset state
    check("rst_a_count", a_count, 0);
    check("rst_a_wrap", a_wrap, 0);
    check("rst_a_sat", a_sat, 0);
    check("rst_a_load_err", a_load_err, 0);
    check("rst_a_at_limit_down", a_at_limit, 1);
    check("rst_b_count", b_count, 0);
    check("rst_c_count", c_count, 0);
    a_rst = 0; b_rst = 0; c_rst = 0;

    // Up count across the wrap: 1..14, 0 (wrap), 1
    a_en = 1; a_mode = 1;
    for (int i = 1; i <= 16; i++) begin
      step();
      check($sformatf("up_count_%0d", i), a_count, (i <= 14) ? i : ((i == 15) ? 0 : 1));
      check($sformatf("up_wrap_%0d", i), a_wrap, (i == 15) ? 1 : 0);
    end

    // Load 3 then count down: 3,2,1,0,14
    a_en = 0; a_load = 1; a_data = 4'd3;
    step();
    check("ld3_count", a_count, 3);
    check("ld3_load_err", a_load_err, 0);
    a_load = 0; a_en = 1; a_mode = 0;
    step(); check("dn_count_2", a_count, 2);
    check("dn_at_limit_2", a_at_limit, 0);
    step(); check("dn_count_1", a_count, 1);
    step(); check("dn_count_0", a_count, 0);
    check("dn_wrap_0", a_wrap, 0);
    check("dn_at_limit_0", a_at_limit, 1);
    step(); check("dn_count_14", a_count, 14);
    check("dn_wrap_14", a_wrap, 1);
    check("dn_at_limit_14", a_at_limit, 0);

    // Out-of-range load clamps to 14; load beats en
    a_en = 0; a_load = 1; a_data = 4'd15;
    step();
    check("ld15_count", a_count, 14);
    check("ld15_load_err", a_load_err, 1);
    a_data = 4'd9; a_en = 1; a_mode = 1;
    step();
    check("ld9_count", a_count, 9);
    check("ld9_load_err", a_load_err, 0);
    check("ld9_wrap", a_wrap, 0);
    a_load = 0; a_en = 0;
    step();
    check("hold_count", a_count, 9);
    check("hold_load_err", a_load_err, 0);

    // Load at limit with en up: load wins, no wrap
    a_load = 1; a_data = 4'd14; a_en = 1; a_mode = 1;
    step();
    check("ld14_count", a_count, 14);
    check("ld14_at_limit", a_at_limit, 1);
    a_load = 1; a_data = 4'd14;
    step();
    check("ld14_again_wrap", a_wrap, 0);

    // Direction change takes effect immediately
    a_load = 0; a_en = 1; a_mode = 1;
    step(); check("turn_up_count", a_count, 0);
    step(); check("turn_up_count2", a_count, 1);
    a_mode = 0;
    step(); check("turn_dn_count", a_count, 0);
    check("turn_dn_wrap", a_wrap, 0);

    // Reset overrides load; resume from 0
    a_en = 0; a_load = 1; a_data = 4'd6;
    step(); check("ld6_count", a_count, 6);
    a_rst = 1; a_load = 1; a_data = 4'd2; a_en = 1; a_mode = 1;
    step();
    check("rst_ovr_count", a_count, 0);
    check("rst_ovr_load_err", a_load_err, 0);
    a_rst = 0; a_load = 0;
    step(); check("rst_resume_count", a_count, 1);
    a_en = 0;

    // Saturating instance: up from 7 -> 8,9,9,9,9
    b_load = 1; b_data = 4'd7;
    step(); check("b_ld7_count", b_count, 7);
    b_load = 0; b_en = 1; b_mode = 1;
    for (int i = 1; i <= 5; i++) begin
      step();
      check($sformatf("b_up_count_%0d", i), b_count, (i == 1) ? 8 : 9);
      check($sformatf("b_up_sat_%0d", i), b_sat, (i >= 3) ? 1 : 0);
      check($sformatf("b_up_wrap_%0d", i), b_wrap, 0);
    end
    b_en = 0;
    step();
    check("b_idle_sat", b_sat, 0);
    check("b_idle_count", b_count, 9);
    // Down at 0 holds
    b_load = 1; b_data = 4'd0;
    step();
    b_load = 0; b_en = 1; b_mode = 0;
    step();
    check("b_dn0_count", b_count, 0);
    check("b_dn0_sat", b_sat, 1);
    check("b_dn0_wrap", b_wrap, 0);
    // Out-of-range load clamps to 9
    b_en = 0; b_load = 1; b_data = 4'd12;
    step();
    check("b_ld12_count", b_count, 9);
    check("b_ld12_load_err", b_load_err, 1);
    check("b_ld12_sat", b_sat, 0);
    b_load = 0;

    // Full-range instance: 7 -> 0 up, 0 -> 7 down
    c_load = 1; c_data = 3'd7;
    step();
    check("c_ld7_count", c_count, 7);
    check("c_ld7_load_err", c_load_err, 0);
    c_load = 0; c_en = 1; c_mode = 1;
    step();
    check("c_up_count", c_count, 0);
    check("c_up_wrap", c_wrap, 1);
    c_mode = 0;
    step();
    check("c_dn_count", c_count, 7);
    check("c_dn_wrap", c_wrap, 1);
    step();
    check("c_dn2_count", c_count, 6);
    check("c_dn2_wrap", c_wrap, 0);
    c_en = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
